tv80_alu16_seq: RTL and testbench



---
 rtl/tv80_alu16_seq_if.sv | 36 +++
 rtl/tv80_alu16_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_tv80_alu16_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tv80_alu16_seq_if.sv
// ---------------------------------------------------------------------------
// tv80_alu16_seq_if
// Request/response handshake between the execute stage and the 16-bit
// ALU sequencer.
//   req_valid/req_ready : request handshake (op, A, B, F travel with it)
//   req_op              : 00 ADD16, 01 ADC16, 10 SBC16, 11 SUB16
//   req_a / req_b       : 16-bit operands (HL / rr)
//   req_f               : incoming flag byte
//   rsp_valid/rsp_ready : response handshake
//   rsp_q / rsp_f       : 16-bit result and result flags
//   busy                : sequencer owns the shared ALU
// master = requester side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface tv80_alu16_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_f;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_q;
  logic [7:0]  rsp_f;
  logic        busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_f, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_f, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_f, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_f, busy
  );
endinterface

// File: rtl/tv80_alu16_seq.sv
// ---------------------------------------------------------------------------
// tv80_alu16_seq
// Runs a 16-bit ADD/ADC/SBC/SUB as two passes through the shared 8-bit TV80
// ALU: low byte first, then high byte with the low pass's flags chained in.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : request/response handshake, busy
//   alu_op/alu_busa/alu_busb/alu_fin/alu_arith16/alu_z16 : to the ALU
//   alu_q/alu_fout      : from the ALU (combinational)
// All outputs are registered; the ALU lanes are loaded on the edge that
// enters a pass, so they are stable for the whole pass, and are zero
// whenever the sequencer does not own the ALU.
// ---------------------------------------------------------------------------
module tv80_alu16_seq #(
  parameter int FLAG_C = 0,
  parameter int FLAG_Z = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  tv80_alu16_seq_if.slave bus,
  output logic [3:0]      alu_op,
  output logic [7:0]      alu_busa,
  output logic [7:0]      alu_busb,
  output logic [7:0]      alu_fin,
  output logic            alu_arith16,
  output logic            alu_z16,
  input  logic [7:0]      alu_q,
  input  logic [7:0]      alu_fout
);

  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_ADC16 = 2'b01;
  localparam logic [1:0] OP_SBC16 = 2'b10;
  localparam logic [1:0] OP_SUB16 = 2'b11;

  // Clears the carry bit so SUB16 starts its low pass without a borrow.
  localparam logic [7:0] CARRY_CLR_MASK = ~(8'd1 << FLAG_C);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;

  logic [1:0]  op_r, op_nxt_s;
  logic [7:0]  a_hi_r, a_hi_nxt_s;
  logic [7:0]  b_hi_r, b_hi_nxt_s;
  logic [7:0]  lo_byte_r, lo_byte_nxt_s;
  logic [15:0] rsp_q_r, rsp_q_nxt_s;
  logic [7:0]  rsp_f_r, rsp_f_nxt_s;
  logic        req_ready_r, req_ready_nxt_s;
  logic        rsp_valid_r, rsp_valid_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic [3:0]  alu_op_r, alu_op_nxt_s;
  logic [7:0]  alu_busa_r, alu_busa_nxt_s;
  logic [7:0]  alu_busb_r, alu_busb_nxt_s;
  logic [7:0]  alu_fin_r, alu_fin_nxt_s;
  logic        alu_arith16_r, alu_arith16_nxt_s;
  logic        alu_z16_r, alu_z16_nxt_s;

  // Z chaining is done inside the ALU via Z16; the index is kept for reference.
  logic        unused_flag_z_s;
  assign unused_flag_z_s = alu_fin_r[FLAG_Z];

  // ALU opcode for the low-byte pass.
  function automatic logic [3:0] lo_pass_op(input logic [1:0] op);
    logic [3:0] r;
    case (op)
      OP_ADD16: r = 4'b0000;
      OP_ADC16: r = 4'b0001;
      OP_SBC16: r = 4'b0011;
      OP_SUB16: r = 4'b0010;
      default:  r = 4'b0000;
    endcase
    return r;
  endfunction

  // ALU opcode for the high-byte pass: always carry/borrow-chained.
  function automatic logic [3:0] hi_pass_op(input logic [1:0] op);
    logic [3:0] r;
    case (op)
      OP_ADD16: r = 4'b0001;
      OP_ADC16: r = 4'b0001;
      OP_SBC16: r = 4'b0011;
      OP_SUB16: r = 4'b0011;
      default:  r = 4'b0000;
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt_s = ST_LO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LO:   state_nxt_s = ST_HI;
      ST_HI:   state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; ALU lanes default to zero (ALU released).
  always_comb begin
    op_nxt_s          = op_r;
    a_hi_nxt_s        = a_hi_r;
    b_hi_nxt_s        = b_hi_r;
    lo_byte_nxt_s     = lo_byte_r;
    rsp_q_nxt_s       = rsp_q_r;
    rsp_f_nxt_s       = rsp_f_r;
    alu_op_nxt_s      = 4'd0;
    alu_busa_nxt_s    = 8'd0;
    alu_busb_nxt_s    = 8'd0;
    alu_fin_nxt_s     = 8'd0;
    alu_arith16_nxt_s = 1'b0;
    alu_z16_nxt_s     = 1'b0;
    req_ready_nxt_s   = (state_nxt_s == ST_IDLE);
    rsp_valid_nxt_s   = (state_nxt_s == ST_DONE);
    busy_nxt_s        = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          // Capture the request and load the low-pass lanes for LO.
          op_nxt_s          = bus.req_op;
          a_hi_nxt_s        = bus.req_a[15:8];
          b_hi_nxt_s        = bus.req_b[15:8];
          alu_op_nxt_s      = lo_pass_op(bus.req_op);
          alu_busa_nxt_s    = bus.req_a[7:0];
          alu_busb_nxt_s    = bus.req_b[7:0];
          if (bus.req_op == OP_SUB16) begin
            alu_fin_nxt_s = bus.req_f & CARRY_CLR_MASK;
          end else begin
            alu_fin_nxt_s = bus.req_f;
          end
          alu_arith16_nxt_s = (bus.req_op == OP_ADD16);
          alu_z16_nxt_s     = 1'b0;
        end else begin
          alu_op_nxt_s = 4'd0;
        end
      end
      ST_LO: begin
        // Keep the low byte, chain the low-pass flags into the high pass.
        lo_byte_nxt_s     = alu_q;
        alu_op_nxt_s      = hi_pass_op(op_r);
        alu_busa_nxt_s    = a_hi_r;
        alu_busb_nxt_s    = b_hi_r;
        alu_fin_nxt_s     = alu_fout;
        alu_arith16_nxt_s = (op_r == OP_ADD16);
        alu_z16_nxt_s     = (op_r != OP_ADD16);
      end
      ST_HI: begin
        rsp_q_nxt_s = {alu_q, lo_byte_r};
        rsp_f_nxt_s = alu_fout;
      end
      ST_DONE: begin
        rsp_q_nxt_s = rsp_q_r;
      end
      default: begin
        rsp_q_nxt_s = rsp_q_r;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r          <= 2'd0;
      a_hi_r        <= 8'd0;
      b_hi_r        <= 8'd0;
      lo_byte_r     <= 8'd0;
      rsp_q_r       <= 16'd0;
      rsp_f_r       <= 8'd0;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      alu_op_r      <= 4'd0;
      alu_busa_r    <= 8'd0;
      alu_busb_r    <= 8'd0;
      alu_fin_r     <= 8'd0;
      alu_arith16_r <= 1'b0;
      alu_z16_r     <= 1'b0;
    end else begin
      op_r          <= op_nxt_s;
      a_hi_r        <= a_hi_nxt_s;
      b_hi_r        <= b_hi_nxt_s;
      lo_byte_r     <= lo_byte_nxt_s;
      rsp_q_r       <= rsp_q_nxt_s;
      rsp_f_r       <= rsp_f_nxt_s;
      req_ready_r   <= req_ready_nxt_s;
      rsp_valid_r   <= rsp_valid_nxt_s;
      busy_r        <= busy_nxt_s;
      alu_op_r      <= alu_op_nxt_s;
      alu_busa_r    <= alu_busa_nxt_s;
      alu_busb_r    <= alu_busb_nxt_s;
      alu_fin_r     <= alu_fin_nxt_s;
      alu_arith16_r <= alu_arith16_nxt_s;
      alu_z16_r     <= alu_z16_nxt_s;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_q     = rsp_q_r;
  assign bus.rsp_f     = rsp_f_r;
  assign bus.busy      = busy_r;
  assign alu_op        = alu_op_r;
  assign alu_busa      = alu_busa_r;
  assign alu_busb      = alu_busb_r;
  assign alu_fin       = alu_fin_r;
  assign alu_arith16   = alu_arith16_r;
  assign alu_z16       = alu_z16_r;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// ---------------------------------------------------------------------------
// tb_tv80_alu16_seq
// Drives the sequencer against a behavioural 8-bit TV80 ALU and checks the
// results against a 16-bit reference computed directly from Z80 16-bit
// arithmetic rules.
// ---------------------------------------------------------------------------
module tb_tv80_alu16_seq;
  logic       clk;
  logic       reset_n;
  logic [3:0] alu_op;
  logic [7:0] alu_busa, alu_busb, alu_fin, alu_q, alu_fout;
  logic       alu_arith16, alu_z16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] lo_tab [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
  logic [3:0] hi_tab [4] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011};

  tv80_alu16_seq_if bus ();

  tv80_alu16_seq #(.FLAG_C(0), .FLAG_Z(6)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb),
    .alu_fin(alu_fin), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
    .alu_q(alu_q), .alu_fout(alu_fout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU for ops ADD/ADC/SUB/SBC (F: S Z Y H X P N C).
  function automatic logic [15:0] alu8(input logic [3:0] op, input logic [7:0] a, b, fi,
                                       input logic ar16, z16);
    int ia, ib, ci, r;
    logic c, h, v, n;
    logic [7:0] q, fo;
    ia = int'(a); ib = int'(b);
    ci = op[0] ? int'(fi[0]) : 0;
    n  = op[1];
    if (!n) begin
      r = ia + ib + ci; c = (r > 255); h = ((ia % 16) + (ib % 16) + ci) > 15;
    end else begin
      r = ia - ib - ci; c = (r < 0);   h = ((ia % 16) - (ib % 16) - ci) < 0;
    end
    q = r[7:0];
    v = n ? ((a[7] != b[7]) && (q[7] != a[7])) : ((a[7] == b[7]) && (q[7] != a[7]));
    fo = {q[7], (q == 8'd0) ? (z16 ? fi[6] : 1'b1) : 1'b0, q[5], h, q[3], v, n, c};
    if (ar16) begin
      fo[7] = fi[7]; fo[6] = fi[6]; fo[2] = fi[2];
    end
    return {q, fo};
  endfunction

  assign {alu_q, alu_fout} = alu8(alu_op, alu_busa, alu_busb, alu_fin, alu_arith16, alu_z16);

  // 16-bit reference: ADD HL keeps S/Z/P; ADC/SBC/SUB compute all flags.
  task automatic model16(input logic [1:0] op, input logic [15:0] a, b, input logic [7:0] f,
                         output logic [15:0] q, output logic [7:0] fo);
    int ia, ib, ci, r;
    logic c, h, v, n;
    ia = int'(a); ib = int'(b);
    ci = (op == 2'b01 || op == 2'b10) ? int'(f[0]) : 0;
    n  = op[1];
    if (!n) begin
      r = ia + ib + ci; c = (r > 65535); h = ((ia % 4096) + (ib % 4096) + ci) > 4095;
    end else begin
      r = ia - ib - ci; c = (r < 0);     h = ((ia % 4096) - (ib % 4096) - ci) < 0;
    end
    q = r[15:0];
    v = n ? ((a[15] != b[15]) && (q[15] != a[15])) : ((a[15] == b[15]) && (q[15] != a[15]));
    if (op == 2'b00) fo = {f[7], f[6], q[13], h, q[11], f[2], 1'b0, c};
    else             fo = {q[15], (q == 16'd0), q[13], h, q[11], v, n, c};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] lanes();
    return 32'({alu_op, alu_busa, alu_busb, alu_fin, alu_arith16, alu_z16});
  endfunction

  // One full operation starting in IDLE. Optionally leaves a pending request
  // on the bus from DONE onwards (accepted in the following IDLE cycle).
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, b, input logic [7:0] f,
                        input int stall, input bit pend, input logic [1:0] p_op,
                        input logic [15:0] p_a, p_b, input logic [7:0] p_f,
                        input bit use_exp, input logic [15:0] xq, input logic [7:0] xf);
    logic [15:0] eq;
    logic [7:0]  ef, lo_fout, fin_lo;
    model16(op, a, b, f, eq, ef);
    if (use_exp) begin
      eq = xq; ef = xf;
    end
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_f = f; bus.req_valid = 1'b1;
    tick();
    // LO pass
    fin_lo = (op == 2'b11) ? (f & 8'hFE) : f;
    check("lo_status", 32'({bus.busy, bus.req_ready, bus.rsp_valid}), 32'b100);
    check("lo_lanes", lanes(), 32'({lo_tab[op], a[7:0], b[7:0], fin_lo, (op == 2'b00), 1'b0}));
    lo_fout = alu_fout;
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_op = 2'($urandom); bus.req_a = 16'($urandom);
    bus.req_b = 16'($urandom); bus.req_f = 8'($urandom);
    tick();
    // HI pass
    check("hi_lanes", lanes(), 32'({hi_tab[op], a[15:8], b[15:8], lo_fout, (op == 2'b00), (op != 2'b00)}));
    check("hi_valid", 32'(bus.rsp_valid), 32'd0);
    if (pend) begin
      bus.req_op = p_op; bus.req_a = p_a; bus.req_b = p_b; bus.req_f = p_f; bus.req_valid = 1'b1;
    end else begin
      bus.req_valid = 1'b0;
    end
    tick();
    // DONE
    check("done_valid", 32'({bus.rsp_valid, bus.req_ready, bus.busy}), 32'b101);
    check("done_q", 32'(bus.rsp_q), 32'(eq));
    check("done_f", 32'(bus.rsp_f), 32'(ef));
    check("done_lanes", lanes(), 32'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_hold", 32'({bus.rsp_valid, bus.req_ready, bus.rsp_f, bus.rsp_q}),
            32'({1'b1, 1'b0, ef, eq}));
      check("stall_lanes", lanes(), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("back_idle", 32'({bus.req_ready, bus.rsp_valid, bus.busy}), 32'b100);
    check("idle_lanes", lanes(), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [15:0] r_a, r_b;
    logic [7:0]  r_f;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_a = 16'd0;
    bus.req_b = 16'd0; bus.req_f = 8'd0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid_busy", 32'({bus.rsp_valid, bus.busy}), 32'd0);
    check("rst_q", 32'(bus.rsp_q), 32'd0);
    check("rst_f", 32'(bus.rsp_f), 32'd0);
    check("rst_lanes", lanes(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Directed vectors. ADD16 H comes from the bit-11 carry
    // (0x234 + 0xFCC overflows 12 bits), so H is set in 0xF4.
    run_op(2'b00, 16'h1234, 16'h0FCC, 8'hFF, 0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 1'b1, 16'h2200, 8'hF4);
    run_op(2'b01, 16'h00FF, 16'h0001, 8'h00, 0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 1'b1, 16'h0100, 8'h00);
    run_op(2'b10, 16'h1000, 16'h1000, 8'h00, 0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 1'b1, 16'h0000, 8'h42);
    run_op(2'b10, 16'h8000, 16'h0001, 8'h00, 0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 1'b1, 16'h7FFF, 8'h3E);
    // SUB16 must ignore an incoming carry.
    run_op(2'b11, 16'h5000, 16'h1000, 8'h01, 0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 1'b1, 16'h4000, 8'h02);

    // Reset during HI: outputs drop immediately, stale result discarded.
    bus.req_op = 2'b01; bus.req_a = 16'hABCD; bus.req_b = 16'h1111; bus.req_f = 8'h00;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_status", 32'({bus.rsp_valid, bus.req_ready, bus.busy}), 32'b010);
    check("mid_rst_q", 32'(bus.rsp_q), 32'd0);
    check("mid_rst_lanes", lanes(), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_op(2'b00, 16'h0F0F, 16'h0101, 8'h44, 0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 1'b0, 16'd0, 8'd0);

    // Backpressure for 5 cycles with a second request pending, then back-to-back.
    run_op(2'b01, 16'h7FFF, 16'h0001, 8'h01, 5, 1'b1, 2'b10, 16'h0000, 16'h0001, 8'h00,
           1'b0, 16'd0, 8'd0);
    run_op(2'b10, 16'h0000, 16'h0001, 8'h00, 0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 1'b0, 16'd0, 8'd0);

    // Randomised operations.
    for (int k = 0; k < 150; k++) begin
      r_op = 2'($urandom); r_a = 16'($urandom); r_b = 16'($urandom); r_f = 8'($urandom);
      if (k % 10 == 0) r_b = r_a;
      run_op(r_op, r_a, r_b, r_f, $urandom_range(0, 3), 1'b0, 2'd0, 16'd0, 16'd0, 8'd0,
             1'b0, 16'd0, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
